// File: rtl/channel_alloc.sv
// channel_alloc: per-channel allocator for bidirectional router links.
//
// Each output channel runs its own IN/ACQ/OUT/BUSY state machine. A channel
// must own the link direction (OUT) before it can be granted to a router port.
// A channel in IN negotiates the direction with the neighbour over a
// req/ack handshake. Grants are round-robin per channel. A port never holds
// more than one channel.
//
// Ports:
//   clk               rising-edge clock
//   rst               synchronous, active-low reset
//   channel_req_flat  [p*NCH+c] port p requests channel c
//   channel_gnt_flat  [p*NCH+c] channel c granted to port p
//   sel_flat          [4c+3:4c] owner port of channel c (output mux select)
//   inout_select      per channel, 1 = drive the link, 0 = receive
//   dir_req_out       ask neighbour to hand over channel direction
//   dir_ack_in        neighbour's 1-cycle acknowledge of dir_req_out
//   dir_req_in        neighbour asks for channel direction
//   dir_ack_out       1-cycle pulse releasing the channel to the neighbour
module channel_alloc #(
  parameter int              NP       = 10,
  parameter int              NCH      = 10,
  parameter logic [NCH-1:0]  INIT_DIR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NP*NCH-1:0]   channel_req_flat,
  output logic [NP*NCH-1:0]   channel_gnt_flat,
  output logic [4*NCH-1:0]    sel_flat,
  output logic [NCH-1:0]      inout_select,
  output logic [NCH-1:0]      dir_req_out,
  input  logic [NCH-1:0]      dir_ack_in,
  input  logic [NCH-1:0]      dir_req_in,
  output logic [NCH-1:0]      dir_ack_out
);

  typedef enum logic [1:0] {
    ST_IN   = 2'd0,
    ST_ACQ  = 2'd1,
    ST_OUT  = 2'd2,
    ST_BUSY = 2'd3
  } state_t;

  state_t          state_reg  [NCH];
  logic [NP-1:0]   gnt_reg    [NCH];
  logic [3:0]      sel_reg    [NCH];
  logic [3:0]      rr_reg     [NCH];
  logic [NCH-1:0]  yield_reg;   // neighbour was waiting when BUSY ended
  logic [NCH-1:0]  inout_reg;
  logic [NCH-1:0]  dreq_reg;
  logic [NCH-1:0]  dack_reg;

  logic [NP-1:0]   req_ch     [NCH];
  logic [NP-1:0]   elig       [NCH];
  logic [NP-1:0]   win_onehot [NCH];
  logic [3:0]      win_idx    [NCH];
  logic [NP-1:0]   port_busy;
  logic [NCH-1:0]  elig_any;
  logic [NCH-1:0]  grant_now;
  logic [NCH-1:0]  yield_now;

  // Arbitration for all channels. Channels are visited in ascending order so
  // that a port winning several channels in one cycle is granted only the
  // lowest one; the others see it as claimed and stay in OUT.
  always_comb begin
    int            idx;
    logic          found;
    logic [3:0]    cand;
    logic [NP-1:0] claimed;

    idx       = 0;
    cand      = '0;
    claimed   = '0;
    port_busy = '0;
    for (int c = 0; c < NCH; c++) begin
      port_busy = port_busy | gnt_reg[c];
    end

    for (int c = 0; c < NCH; c++) begin
      req_ch[c] = '0;
      for (int p = 0; p < NP; p++) begin
        req_ch[c][p] = channel_req_flat[p*NCH + c];
      end
      elig[c] = req_ch[c] & ~port_busy;

      found         = 1'b0;
      win_idx[c]    = '0;
      win_onehot[c] = '0;
      for (int k = 0; k < NP; k++) begin
        idx = int'(rr_reg[c]) + k;
        if (idx >= NP) begin
          idx = idx - NP;
        end
        cand = 4'(idx);
        if (!found && elig[c][cand]) begin
          found              = 1'b1;
          win_idx[c]         = cand;
          win_onehot[c][cand] = 1'b1;
        end
      end
      elig_any[c] = |elig[c];

      // A pending yield (neighbour waited through a BUSY period) beats local
      // requesters; otherwise local requesters beat the neighbour.
      yield_now[c] = (state_reg[c] == ST_OUT) && dir_req_in[c] &&
                     (yield_reg[c] || !elig_any[c]);

      grant_now[c] = 1'b0;
      if ((state_reg[c] == ST_OUT) && elig_any[c] && !yield_now[c] &&
          !claimed[win_idx[c]]) begin
        grant_now[c]         = 1'b1;
        claimed[win_idx[c]]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (!rst) begin
        state_reg[c] <= INIT_DIR[c] ? ST_OUT : ST_IN;
        gnt_reg[c]   <= '0;
        sel_reg[c]   <= '0;
        rr_reg[c]    <= '0;
        yield_reg[c] <= 1'b0;
        inout_reg[c] <= INIT_DIR[c];
        dreq_reg[c]  <= 1'b0;
        dack_reg[c]  <= 1'b0;
      end else begin
        dack_reg[c] <= 1'b0;
        case (state_reg[c])
          ST_IN: begin
            if (|req_ch[c]) begin
              state_reg[c] <= ST_ACQ;
              dreq_reg[c]  <= 1'b1;
            end
          end
          ST_ACQ: begin
            // Requests may vanish here; the handshake is still completed.
            if (dir_ack_in[c]) begin
              state_reg[c] <= ST_OUT;
              dreq_reg[c]  <= 1'b0;
              inout_reg[c] <= 1'b1;
            end
          end
          ST_OUT: begin
            yield_reg[c] <= 1'b0;
            if (grant_now[c]) begin
              state_reg[c] <= ST_BUSY;
              gnt_reg[c]   <= win_onehot[c];
              sel_reg[c]   <= win_idx[c];
            end else if (yield_now[c]) begin
              state_reg[c] <= ST_IN;
              inout_reg[c] <= 1'b0;
              dack_reg[c]  <= 1'b1;
            end
          end
          ST_BUSY: begin
            if (!req_ch[c][sel_reg[c]]) begin
              state_reg[c] <= ST_OUT;
              gnt_reg[c]   <= '0;
              rr_reg[c]    <= (int'(sel_reg[c]) == NP - 1) ? 4'd0 : sel_reg[c] + 4'd1;
              yield_reg[c] <= dir_req_in[c];
            end
          end
        endcase
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_out
      assign sel_flat[4*gi +: 4] = sel_reg[gi];
      for (genvar gj = 0; gj < NP; gj++) begin : g_port
        assign channel_gnt_flat[gj*NCH + gi] = gnt_reg[gi][gj];
      end
    end
  endgenerate

  assign inout_select = inout_reg;
  assign dir_req_out  = dreq_reg;
  assign dir_ack_out  = dack_reg;

endmodule

// File: tb/tb_channel_alloc.sv
// Testbench for channel_alloc: directed vector table for the key scenarios,
// then randomized traffic checked against a behavioural ownership model.
module tb_channel_alloc;

  localparam int NP  = 10;
  localparam int NCH = 10;
  localparam int NB  = NP * NCH;
  localparam logic [NCH-1:0] INIT  = 10'b0010001111;
  localparam logic [NCH-1:0] IO_5  = 10'b0010101111;
  localparam logic [NCH-1:0] IO_57 = 10'b0000101111;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NB-1:0]     channel_req_flat = '0;
  logic [NB-1:0]     channel_gnt_flat;
  logic [4*NCH-1:0]  sel_flat;
  logic [NCH-1:0]    inout_select;
  logic [NCH-1:0]    dir_req_out;
  logic [NCH-1:0]    dir_ack_in = '0;
  logic [NCH-1:0]    dir_req_in = '0;
  logic [NCH-1:0]    dir_ack_out;

  always #5 clk = ~clk;

  channel_alloc #(.NP(NP), .NCH(NCH), .INIT_DIR(INIT)) dut (
    .clk              (clk),
    .rst              (rst),
    .channel_req_flat (channel_req_flat),
    .channel_gnt_flat (channel_gnt_flat),
    .sel_flat         (sel_flat),
    .inout_select     (inout_select),
    .dir_req_out      (dir_req_out),
    .dir_ack_in       (dir_ack_in),
    .dir_req_in       (dir_req_in),
    .dir_ack_out      (dir_ack_out)
  );

  int vecs = 0;
  int errs = 0;

  function automatic logic [NB-1:0] g(int p, int c);
    logic [NB-1:0] v;
    v = '0;
    v[p*NCH + c] = 1'b1;
    return v;
  endfunction

  function automatic logic [NCH-1:0] b(int c);
    logic [NCH-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic chk(string nm, logic [NB-1:0] got, logic [NB-1:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  typedef struct {
    string          nm;
    logic           r;
    logic [NB-1:0]  req;
    logic [NCH-1:0] ack;
    logic [NCH-1:0] drq;
    logic [NB-1:0]  gnt;
    logic [NCH-1:0] io;
    logic [NCH-1:0] dro;
    logic [NCH-1:0] dak;
    int             sc;
    logic [3:0]     sv;
  } vec_t;

  vec_t tbl[$];

  task automatic add(string nm, logic r, logic [NB-1:0] req, logic [NCH-1:0] ack,
                     logic [NCH-1:0] drq, logic [NB-1:0] gnt, logic [NCH-1:0] io,
                     logic [NCH-1:0] dro, logic [NCH-1:0] dak, int sc, logic [3:0] sv);
    vec_t v;
    v.nm = nm; v.r = r; v.req = req; v.ack = ack; v.drq = drq; v.gnt = gnt;
    v.io = io; v.dro = dro; v.dak = dak; v.sc = sc; v.sv = sv;
    tbl.push_back(v);
  endtask

  // ---------------- behavioural model ----------------
  // Channel modes: 0 receive, 1 acquiring, 2 drive/free, 3 drive/owned.
  int   m_mode  [NCH];
  int   m_owner [NCH];
  int   m_ptr   [NCH];
  int   m_sel   [NCH];
  bit   m_pend  [NCH];
  bit   m_io    [NCH];
  bit   m_dro   [NCH];
  bit   m_dak   [NCH];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = INIT[c] ? 2 : 0;
      m_owner[c] = -1; m_ptr[c] = 0; m_sel[c] = 0; m_pend[c] = 0;
      m_io[c] = INIT[c]; m_dro[c] = 0; m_dak[c] = 0;
    end
  endtask

  task automatic model_step(logic rn, logic [NB-1:0] req, logic [NCH-1:0] ack,
                            logic [NCH-1:0] drq);
    bit holding [NP];
    bit taken   [NP];
    if (!rn) begin
      model_reset();
      return;
    end
    for (int p = 0; p < NP; p++) begin
      holding[p] = 0; taken[p] = 0;
    end
    for (int c = 0; c < NCH; c++)
      if (m_mode[c] == 3) holding[m_owner[c]] = 1;
    for (int c = 0; c < NCH; c++) begin
      bit any_req;
      int win;
      m_dak[c] = 0;
      any_req = 0;
      for (int p = 0; p < NP; p++) if (req[p*NCH + c]) any_req = 1;
      case (m_mode[c])
        0: if (any_req) begin m_mode[c] = 1; m_dro[c] = 1; end
        1: if (ack[c]) begin m_mode[c] = 2; m_dro[c] = 0; m_io[c] = 1; end
        2: begin
          win = -1;
          for (int k = 0; k < NP; k++) begin
            int p;
            p = (m_ptr[c] + k) % NP;
            if (win < 0 && req[p*NCH + c] && !holding[p]) win = p;
          end
          if (drq[c] && (m_pend[c] || win < 0)) begin
            m_mode[c] = 0; m_io[c] = 0; m_dak[c] = 1;
          end else if (win >= 0 && !taken[win]) begin
            m_mode[c] = 3; m_owner[c] = win; m_sel[c] = win; taken[win] = 1;
          end
          m_pend[c] = 0;
        end
        default: if (!req[m_owner[c]*NCH + c]) begin
          m_mode[c] = 2;
          m_ptr[c] = (m_owner[c] + 1) % NP;
          m_pend[c] = drq[c];
          m_owner[c] = -1;
        end
      endcase
    end
  endtask

  task automatic model_compare();
    logic [NB-1:0]    eg;
    logic [4*NCH-1:0] es;
    logic [NCH-1:0]   eio, edro, edak;
    eg = '0; es = '0; eio = '0; edro = '0; edak = '0;
    for (int c = 0; c < NCH; c++) begin
      if (m_mode[c] == 3) eg[m_owner[c]*NCH + c] = 1'b1;
      es[4*c +: 4] = 4'(m_sel[c]);
      eio[c] = m_io[c]; edro[c] = m_dro[c]; edak[c] = m_dak[c];
    end
    chk("rnd_gnt",   channel_gnt_flat, eg);
    chk("rnd_sel",   NB'(sel_flat),    NB'(es));
    chk("rnd_inout", NB'(inout_select), NB'(eio));
    chk("rnd_dreq",  NB'(dir_req_out),  NB'(edro));
    chk("rnd_dack",  NB'(dir_ack_out),  NB'(edak));
  endtask

  initial begin
    logic [NCH-1:0] cur_req [NP];
    logic [NB-1:0]  both0;
    logic [NB-1:0]  r33;
    both0 = g(1,0) | g(3,0);
    r33   = g(6,1) | g(6,3) | g(8,3);

    // name     rst req            ack    drq    gnt                io     dro   dak   sc sv
    add("reset",   0, '0,          '0,    '0,    '0,                INIT,  '0,   '0,   2, 0);
    add("r29_req", 1, g(4,2),      '0,    '0,    g(4,2),            INIT,  '0,   '0,   2, 4);
    for (int i = 0; i < 4; i++)
      add("r29_hold", 1, g(4,2),   '0,    '0,    g(4,2),            INIT,  '0,   '0,   2, 4);
    add("r29_drop", 1, '0,         '0,    '0,    '0,                INIT,  '0,   '0,   2, 4);
    add("r30_a",   1, both0,       '0,    '0,    g(1,0),            INIT,  '0,   '0,   0, 1);
    add("r30_b",   1, both0,       '0,    '0,    g(1,0),            INIT,  '0,   '0,   0, 1);
    add("r30_c",   1, g(3,0),      '0,    '0,    '0,                INIT,  '0,   '0,   0, 1);
    add("r30_d",   1, both0,       '0,    '0,    g(3,0),            INIT,  '0,   '0,   0, 3);
    add("r30_e",   1, g(1,0),      '0,    '0,    '0,                INIT,  '0,   '0,   0, 3);
    add("r30_f",   1, both0,       '0,    '0,    g(1,0),            INIT,  '0,   '0,   0, 1);
    add("r30_g",   1, g(3,0),      '0,    '0,    '0,                INIT,  '0,   '0,   0, 1);
    add("r30_h",   1, both0,       '0,    '0,    g(3,0),            INIT,  '0,   '0,   0, 3);
    add("r30_i",   1, '0,          '0,    '0,    '0,                INIT,  '0,   '0,   0, 3);
    add("r31_a",   1, g(0,5),      '0,    '0,    '0,                INIT,  b(5), '0,   -1, 0);
    add("r31_b",   1, g(0,5),      '0,    '0,    '0,                INIT,  b(5), '0,   -1, 0);
    add("r31_ack", 1, g(0,5),      b(5),  '0,    '0,                IO_5,  '0,   '0,   -1, 0);
    add("r31_gnt", 1, g(0,5),      '0,    '0,    g(0,5),            IO_5,  '0,   '0,   5, 0);
    add("r31_ign", 1, '0,          b(8),  b(9),  '0,                IO_5,  '0,   '0,   -1, 0);
    add("r32_a",   1, g(5,7),      '0,    '0,    g(5,7),            IO_5,  '0,   '0,   7, 5);
    add("r32_b",   1, g(5,7),      '0,    b(7),  g(5,7),            IO_5,  '0,   '0,   7, 5);
    add("r32_rel", 1, g(2,7),      '0,    b(7),  '0,                IO_5,  '0,   '0,   7, 5);
    add("r32_yld", 1, g(2,7),      '0,    b(7),  '0,                IO_57, '0,   b(7), 7, 5);
    add("r32_in",  1, g(2,7),      '0,    '0,    '0,                IO_57, b(7), '0,   -1, 0);
    add("r32_acq", 1, '0,          '0,    '0,    '0,                IO_57, b(7), '0,   -1, 0);
    add("r32_ack", 1, '0,          b(7),  '0,    '0,                IO_5,  '0,   '0,   -1, 0);
    add("r32_gnt", 1, g(2,7),      '0,    '0,    g(2,7),            IO_5,  '0,   '0,   7, 2);
    add("r32_end", 1, '0,          '0,    '0,    '0,                IO_5,  '0,   '0,   -1, 0);
    add("r33_a",   1, r33,         '0,    '0,    g(6,1),            IO_5,  '0,   '0,   3, 0);
    add("r33_b",   1, r33,         '0,    '0,    g(6,1) | g(8,3),   IO_5,  '0,   '0,   3, 8);
    add("r33_end", 1, '0,          '0,    '0,    '0,                IO_5,  '0,   '0,   1, 6);
    add("r34_a",   1, g(4,2)|g(7,6), '0,  '0,    g(4,2),            IO_5,  b(6), '0,   2, 4);
    add("r34_rst", 0, g(4,2)|g(7,6), '0,  '0,    '0,                INIT,  '0,   '0,   2, 0);
    add("r34_rel", 1, '0,          '0,    '0,    '0,                INIT,  '0,   '0,   6, 0);
    add("r34_idl", 1, '0,          '0,    '0,    '0,                INIT,  '0,   '0,   -1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r;
      channel_req_flat = tbl[i].req;
      dir_ack_in = tbl[i].ack;
      dir_req_in = tbl[i].drq;
      @(posedge clk);
      #1;
      chk({tbl[i].nm, "_gnt"},   channel_gnt_flat, tbl[i].gnt);
      chk({tbl[i].nm, "_inout"}, NB'(inout_select), NB'(tbl[i].io));
      chk({tbl[i].nm, "_dreq"},  NB'(dir_req_out),  NB'(tbl[i].dro));
      chk({tbl[i].nm, "_dack"},  NB'(dir_ack_out),  NB'(tbl[i].dak));
      if (tbl[i].sc >= 0)
        chk({tbl[i].nm, "_sel"}, NB'(sel_flat[4*tbl[i].sc +: 4]), NB'(tbl[i].sv));
    end

    // Randomized traffic against the model, starting from reset.
    for (int p = 0; p < NP; p++) cur_req[p] = '0;
    rst = 1'b0; channel_req_flat = '0; dir_ack_in = '0; dir_req_in = '0;
    @(posedge clk);
    model_reset();
    #1;
    model_compare();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic [NB-1:0] rq;
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 5) == 0) begin
          case ($urandom_range(0, 2))
            0: cur_req[p] = '0;
            1: cur_req[p] = b($urandom_range(0, NCH-1));
            default: cur_req[p] = b($urandom_range(0, NCH-1)) | b($urandom_range(0, NCH-1));
          endcase
        end
      end
      rq = '0;
      for (int p = 0; p < NP; p++)
        for (int c = 0; c < NCH; c++)
          rq[p*NCH + c] = cur_req[p][c];
      channel_req_flat = rq;
      for (int c = 0; c < NCH; c++) begin
        dir_ack_in[c] = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 7) == 0) dir_req_in[c] = ~dir_req_in[c];
      end
      rst = ($urandom_range(0, 299) != 0);
      @(posedge clk);
      model_step(rst, channel_req_flat, dir_ack_in, dir_req_in);
      #1;
      model_compare();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/channel_alloc.md
CHANNEL_ALLOC -- requirements
Module: channel_alloc

Interface
REQ-001 Parameter NP, default 10: number of router ports driving channel requests.
REQ-002 Parameter NCH, default 10: number of bidirectional output channels.
REQ-003 Parameter INIT_DIR, default 10'b0: per-channel direction after reset, 1 = output; the two ends of each link SHALL be configured complementary.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 channel_req_flat  input  NP*NCH  bits [p*NCH+c]: port p requests channel c (RC channel_req).
REQ-007 channel_gnt_flat  output  NP*NCH  bits [p*NCH+c]: channel c granted to port p (RC channel_gnt).
REQ-008 sel_flat  output  4*NCH  bits [4c+3:4c]: output-mux select (owner port) for channel c.
REQ-009 inout_select  output  NCH  per channel, 1 = drive the link (output), 0 = receive.
REQ-010 dir_req_out  output  NCH  request to the neighbour to hand channel direction over.
REQ-011 dir_ack_in  input  NCH  neighbour acknowledgement (1-cycle pulse) of dir_req_out.
REQ-012 dir_req_in  input  NCH  neighbour requests direction of channel c.
REQ-013 dir_ack_out  output  NCH  1-cycle pulse releasing channel c to the neighbour.

Function
REQ-014 Each channel SHALL run an independent FSM with states IN, ACQ, OUT, BUSY; all outputs SHALL be registered.
REQ-015 IN: inout_select=0; if any port requests c, go to ACQ next cycle.
REQ-016 ACQ: dir_req_out=1, held until dir_ack_in=1; on ack go to OUT; if all requests for c drop before ack, keep dir_req_out asserted until ack, then go to OUT.
REQ-017 OUT: inout_select=1; if any eligible requester exists, go to BUSY and assert gnt to the winner in the next cycle (request-to-grant latency = 1 cycle from OUT).
REQ-018 OUT with no eligible requester and dir_req_in=1: pulse dir_ack_out for exactly 1 cycle, go to IN.
REQ-019 OUT with an eligible requester and dir_req_in=1 in the same cycle: local requester wins; neighbour waits.
REQ-020 BUSY: gnt bit [owner*NCH+c] held high while channel_req[owner][c]=1; when the request drops, gnt drops the following cycle and the FSM goes to OUT.
REQ-021 Anti-starvation: on leaving BUSY with dir_req_in=1, the FSM SHALL yield (REQ-018) before granting any new local request.
REQ-022 Arbitration per channel SHALL be round-robin: search starts at pointer rr[c], which becomes owner+1 (mod NP) when BUSY is left.
REQ-023 A port SHALL hold at most one grant; a port already granted any channel is ineligible elsewhere.
REQ-024 If one port wins several channels in the same cycle, only the lowest-index channel grants; the others stay in OUT and re-arbitrate next cycle.
REQ-025 sel[c] SHALL load the owner index on entry to BUSY and hold it until the next grant.
REQ-026 dir_ack_in while not in ACQ, and dir_req_in while in IN or ACQ, SHALL be ignored.

Reset
REQ-027 While rst=0 at a clock edge: channel FSMs go to OUT where INIT_DIR[c]=1, else IN; inout_select=INIT_DIR; all gnt, dir_req_out and dir_ack_out go to 0; sel and rr go to 0.
REQ-028 Reset asserted mid-grant or mid-handshake SHALL abandon it with no residual pulse after release.

Verification
REQ-029 INIT_DIR[2]=1, port 4 raises channel 2 request at t -> gnt[4*NCH+2]=1 at t+1, sel[2]=4; request drops at t+5 -> gnt=0 at t+6.
REQ-030 Ports 1 and 3 request channel 0 continuously in OUT -> grants alternate 1,3,1,3 across successive releases.
REQ-031 Channel 5 in IN, port 0 requests -> dir_req_out[5]=1 next cycle; dir_ack_in[5] pulse -> inout_select[5]=1, then gnt on the following cycle.
REQ-032 Channel 7 BUSY, dir_req_in[7]=1, owner releases while port 2 requests -> dir_ack_out[7] 1-cycle pulse, inout_select[7]=0, port 2 not granted.
REQ-033 Port 6 requests channels 1 and 3, both in OUT -> only gnt[6*NCH+1]=1; channel 3 is granted to another requester or stays in OUT.
REQ-034 rst=0 during BUSY and ACQ -> all gnt and dir_req_out are 0 at the next edge, and inout_select equals INIT_DIR.
